keypad_scan_controller: RTL and testbench

KEYPAD_SCAN_CONTROLLER -- requirements
Module: keypad_scan_controller

---
 rtl/keypad_scan_controller.sv | 169 ++++++++++++++++
 tb/tb_keypad_scan_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_controller.sv
// Purpose: scans a 4x3 keypad, debounces press and release, emits one key code per press.
// Latency: 2-cycle column sync + DEBOUNCE_CYCLES matches; key_valid rises the edge after accept.
// Backpressure: valid/ready; a key accepted while one is pending and not taken is dropped, setting sticky overflow.
module keypad_scan_controller #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [2:0] col,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] key_code,
  output logic       key_is_digit,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [7:0] SCAN_LAST = 8'(SCAN_CYCLES - 1);
  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state;
  logic [2:0] col_m;
  logic [2:0] col_s;
  logic [1:0] r;
  logic [2:0] lcol;
  logic [7:0] scan_cnt;
  logic [7:0] deb_cnt;
  logic       onehot;
  logic       accept;
  logic [3:0] acc_code;

  // Keypad legend: rows 1-3 are digits 1-9, row 4 is '*', '0', '#'.
  function automatic logic [3:0] map_key(input logic [1:0] ri, input logic [2:0] c);
    logic [3:0] ci;
    logic [3:0] code;
    ci = c[0] ? 4'd0 : (c[1] ? 4'd1 : 4'd2);
    if (ri == 2'd3) begin
      case (ci)
        4'd0:    code = 4'd10;
        4'd1:    code = 4'd0;
        default: code = 4'd11;
      endcase
    end else begin
      code = {2'b00, ri} * 4'd3 + ci + 4'd1;
    end
    return code;
  endfunction

  function automatic logic [3:0] row_of(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Two-flop synchronizer on the asynchronous column sense lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_m <= 3'b000;
      col_s <= 3'b000;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  // Single-key detection and the accept strobe that ends a successful debounce.
  always_comb begin
    onehot   = (col_s != 3'b000) && ((col_s & (col_s - 3'd1)) == 3'b000);
    accept   = (state == DEBOUNCE) && (col_s == lcol) && (deb_cnt >= DEB_LAST);
    acc_code = map_key(r, lcol);
  end

  // Scan/debounce FSM; row and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      r        <= 2'd0;
      row      <= 4'b0001;
      lcol     <= 3'b000;
      scan_cnt <= 8'd0;
      deb_cnt  <= 8'd0;
      busy     <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (scan_cnt >= SCAN_LAST) begin
            scan_cnt <= 8'd0;
            if (onehot) begin
              // Hold the current row and examine this column.
              lcol    <= col_s;
              deb_cnt <= 8'd0;
              state   <= DEBOUNCE;
              busy    <= 1'b1;
            end else begin
              r   <= r + 2'd1;
              row <= row_of(r + 2'd1);
            end
          end else begin
            scan_cnt <= scan_cnt + 8'd1;
          end
        end
        DEBOUNCE: begin
          if (col_s == lcol) begin
            if (deb_cnt >= DEB_LAST) begin
              deb_cnt <= 8'd0;
              state   <= PRESSED;
            end else begin
              deb_cnt <= deb_cnt + 8'd1;
            end
          end else begin
            // Unstable contact: give up and move on to the next row.
            deb_cnt <= 8'd0;
            state   <= SCAN;
            busy    <= 1'b0;
            r       <= r + 2'd1;
            row     <= row_of(r + 2'd1);
          end
        end
        PRESSED: begin
          if ((col_s & lcol) == 3'b000) begin
            deb_cnt <= 8'd0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if ((col_s & lcol) != 3'b000) begin
            // Release bounce: back to held, no new key.
            state <= PRESSED;
          end else if (deb_cnt >= DEB_LAST) begin
            deb_cnt <= 8'd0;
            state   <= SCAN;
            busy    <= 1'b0;
            r       <= r + 2'd1;
            row     <= row_of(r + 2'd1);
          end else begin
            deb_cnt <= deb_cnt + 8'd1;
          end
        end
        default: begin
          state <= SCAN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register with valid/ready handshake and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid    <= 1'b0;
      key_code     <= 4'd0;
      key_is_digit <= 1'b0;
      overflow     <= 1'b0;
    end else if (accept) begin
      if (!key_valid || key_ready) begin
        key_valid    <= 1'b1;
        key_code     <= acc_code;
        key_is_digit <= (acc_code <= 4'd9);
      end else begin
        overflow <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: table of keys, directed corner sequences, random press stream.
module tb_keypad_scan_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [2:0] col;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic       key_is_digit;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int passed = 0;

  // Keypad model: the pressed switch connects row prow to the columns in pmask.
  logic       press_on;
  logic [1:0] prow;
  logic [2:0] pmask;
  assign col = (press_on && row[prow]) ? pmask : 3'b000;

  bit         rand_ready;
  bit         mon_en;
  int         pulses;
  logic [3:0] last_code;
  logic       last_digit;
  int         got_q[$];
  int         exp_q[$];
  int         keymap[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  typedef struct {
    logic [1:0] r;
    logic [2:0] m;
    bit         ev;
    logic [3:0] code;
    logic       digit;
  } vec_t;
  vec_t tbl[14];

  keypad_scan_controller #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_is_digit(key_is_digit), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One clock: settle ready, record a handshake, and verify the pending key held if not taken.
  task automatic cycle();
    logic       hold;
    logic [3:0] hc;
    if (rand_ready) key_ready = 1'($urandom_range(0, 1));
    hold = key_valid && !key_ready;
    hc   = key_code;
    if (key_valid && key_ready) begin
      pulses++;
      last_code  = key_code;
      last_digit = key_is_digit;
      if (mon_en) got_q.push_back(int'(key_code));
    end
    @(negedge clk);
    if (hold) begin
      check("hold_valid", key_valid, 1);
      check("hold_code", key_code, hc);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int maxc, input string name);
    int n = 0;
    while (busy !== lvl && n < maxc) begin
      cycle();
      n++;
    end
    check(name, busy, lvl);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_row"}, row, 4'b0001);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_code"}, key_code, 0);
    check({tag, "_digit"}, key_is_digit, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    tbl[0]  = '{2'd0, 3'b001, 1'b1, 4'd1,  1'b1};
    tbl[1]  = '{2'd0, 3'b010, 1'b1, 4'd2,  1'b1};
    tbl[2]  = '{2'd0, 3'b100, 1'b1, 4'd3,  1'b1};
    tbl[3]  = '{2'd1, 3'b001, 1'b1, 4'd4,  1'b1};
    tbl[4]  = '{2'd1, 3'b010, 1'b1, 4'd5,  1'b1};
    tbl[5]  = '{2'd1, 3'b100, 1'b1, 4'd6,  1'b1};
    tbl[6]  = '{2'd2, 3'b001, 1'b1, 4'd7,  1'b1};
    tbl[7]  = '{2'd2, 3'b010, 1'b1, 4'd8,  1'b1};
    tbl[8]  = '{2'd2, 3'b100, 1'b1, 4'd9,  1'b1};
    tbl[9]  = '{2'd3, 3'b001, 1'b1, 4'd10, 1'b0};
    tbl[10] = '{2'd3, 3'b010, 1'b1, 4'd0,  1'b1};
    tbl[11] = '{2'd3, 3'b100, 1'b1, 4'd11, 1'b0};
    tbl[12] = '{2'd0, 3'b011, 1'b0, 4'd0,  1'b0};
    tbl[13] = '{2'd3, 3'b110, 1'b0, 4'd0,  1'b0};

    reset = 1'b1; key_ready = 1'b0; press_on = 1'b0; prow = 2'd0; pmask = 3'b000;
    rand_ready = 1'b0; mon_en = 1'b0; pulses = 0; last_code = 4'd0; last_digit = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst0");
    reset = 1'b0;

    // Idle scanning: each row held 4 cycles, rows rotate 1->2->3->4->1.
    for (int i = 0; i < 32; i++) begin
      check("idle_row", row, 4'b0001 << ((i / 4) % 4));
      check("idle_valid", key_valid, 0);
      cycle();
    end

    // Key '6' held: one event; a short release is bounce; a full release allows a second event.
    key_ready = 1'b1; pulses = 0;
    prow = 2'd1; pmask = 3'b100; press_on = 1'b1;
    repeat (40) cycle();
    check("k6_pulses", pulses, 1);
    check("k6_code", last_code, 6);
    check("k6_digit", last_digit, 1);
    press_on = 1'b0; repeat (4) cycle();
    press_on = 1'b1; repeat (30) cycle();
    check("k6_bounce_no_event", pulses, 1);
    press_on = 1'b0; repeat (30) cycle();
    press_on = 1'b1; repeat (40) cycle();
    check("k6_second_press", pulses, 2);
    press_on = 1'b0; repeat (30) cycle();

    // '*' bouncing during debounce: no event, scan resumes at row 1; stable re-press gives 10.
    pulses = 0; prow = 2'd3; pmask = 3'b001; press_on = 1'b1;
    wait_busy(1'b1, 40, "star_dbn_enter");
    repeat (3) cycle();
    press_on = 1'b0;
    wait_busy(1'b0, 20, "star_dbn_abort");
    check("star_resume_row", row, 4'b0001);
    check("star_bounce_pulses", pulses, 0);
    press_on = 1'b1; repeat (60) cycle();
    check("star_pulses", pulses, 1);
    check("star_code", last_code, 10);
    check("star_digit", last_digit, 0);
    press_on = 1'b0; repeat (30) cycle();

    // Full key table, including multi-key patterns that must be ignored.
    for (int i = 0; i < 14; i++) begin
      pulses = 0; prow = tbl[i].r; pmask = tbl[i].m; press_on = 1'b1;
      repeat (50) cycle();
      press_on = 1'b0;
      repeat (30) cycle();
      check($sformatf("tbl%0d_pulses", i), pulses, tbl[i].ev ? 1 : 0);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_code", i), last_code, tbl[i].code);
        check($sformatf("tbl%0d_digit", i), last_digit, tbl[i].digit);
      end
    end

    // Overflow: '5' left pending, '#' dropped, then the consumer takes '5'.
    key_ready = 1'b0;
    prow = 2'd1; pmask = 3'b010; press_on = 1'b1;
    repeat (50) cycle();
    check("ovf_valid5", key_valid, 1);
    check("ovf_code5", key_code, 5);
    check("ovf_pre", overflow, 0);
    press_on = 1'b0; repeat (30) cycle();
    prow = 2'd3; pmask = 3'b100; press_on = 1'b1;
    repeat (50) cycle();
    check("ovf_set", overflow, 1);
    check("ovf_code_kept", key_code, 5);
    check("ovf_valid_kept", key_valid, 1);
    press_on = 1'b0; repeat (30) cycle();
    pulses = 0; key_ready = 1'b1;
    cycle();
    check("ovf_taken", pulses, 1);
    check("ovf_taken_code", last_code, 5);
    check("ovf_valid_drop", key_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Reset mid-debounce, then reset with a key pending.
    key_ready = 1'b0;
    prow = 2'd2; pmask = 3'b001; press_on = 1'b1;
    wait_busy(1'b1, 40, "rst_dbn_enter");
    repeat (2) cycle();
    reset = 1'b1;
    @(negedge clk);
    check_reset("rst_dbn");
    reset = 1'b0;
    repeat (50) cycle();
    check("rst_pre_valid", key_valid, 1);
    check("rst_pre_code", key_code, 7);
    reset = 1'b1;
    @(negedge clk);
    check_reset("rst_valid");
    reset = 1'b0;
    press_on = 1'b0;
    repeat (30) cycle();

    // Random press stream with random consumer readiness; short taps must never register.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rand_ready = 1'b1; mon_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        prow = 2'($urandom_range(0, 3));
        pmask = 3'(1 << $urandom_range(0, 2));
        press_on = 1'b1;
        repeat ($urandom_range(1, 5)) cycle();
        press_on = 1'b0;
        repeat (25) cycle();
      end else begin
        int k;
        k = int'($urandom_range(0, 11));
        prow = 2'(k / 3);
        pmask = 3'(1 << (k % 3));
        exp_q.push_back(keymap[k]);
        press_on = 1'b1;
        repeat ($urandom_range(40, 80)) cycle();
        press_on = 1'b0;
        repeat ($urandom_range(25, 40)) cycle();
      end
    end
    repeat (60) cycle();
    rand_ready = 1'b0; mon_en = 1'b0;
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("rand_code%0d", i), got_q[i], exp_q[i]);
    end
    check("rand_no_overflow", overflow, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
